// File: rtl/i2s_tx.sv
// I2S transmitter: resamples divider-supplied mclk/lrck, generates sclk = mclk/2 and shifts 24-bit stereo pairs out MSB first.
// Define I2S_LEFT_JUSTIFIED_EN to emit left-justified frames instead of standard I2S (one-sclk MSB delay).
`timescale 1ns/1ps
`default_nettype none

module i2s_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        mclk_in,
    input  logic        lrck_in,
    input  logic [23:0] sample_l,
    input  logic [23:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        sclk,
    output logic        lrck_out,
    output logic        sdata,
    output logic        underrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic        mclk_q, mclk_d;
    logic        sclk_q, sclk_d;
    logic        lrck_q, lrck_d;
    logic        sdata_q, sdata_d;
    logic        underrun_q, underrun_d;
    logic        hold_full_q, hold_full_d;
    logic [23:0] hold_l_q, hold_l_d;
    logic [23:0] hold_r_q, hold_r_d;
    logic [23:0] shift_l_q, shift_l_d;
    logic [23:0] shift_r_q, shift_r_d;
    logic [1:0]  state_q, state_d;
    logic [5:0]  slot_q, slot_d;

    logic        mclk_rise;
    logic        sclk_fall;
    logic        frame_edge;
    logic        left_edge;
    logic [23:0] sel_word;
    logic [4:0]  bit_idx;
    logic        bit_on;

    always_comb begin
        mclk_rise   = mclk_in & ~mclk_q;
        sclk_fall   = mclk_rise & sclk_q;
        frame_edge  = sclk_fall & (lrck_in ^ lrck_q);
        left_edge   = frame_edge & lrck_q;

        mclk_d      = mclk_in;
        sclk_d      = sclk_q ^ mclk_rise;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        underrun_d  = 1'b0;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        state_d     = state_q;
        slot_d      = slot_q;
        sel_word    = '0;
        bit_idx     = '0;
        bit_on      = 1'b0;

        if (sample_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_l_d    = sample_l;
            hold_r_d    = sample_r;
        end

        // The shift registers double as the "previous pair": an underrun simply keeps them.
        if (left_edge) begin
            if (hold_full_q) begin
                shift_l_d   = hold_l_q;
                shift_r_d   = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d  = 1'b1;
            end
        end

        if (sclk_fall) begin
            lrck_d = lrck_in;
            if (frame_edge) begin
                slot_d = '0;
            end else if (slot_q != 6'd63) begin
                slot_d = slot_q + 6'd1;
            end

            case (state_q)
                ST_IDLE:  if (left_edge)  state_d = ST_LEFT;
                ST_LEFT:  if (frame_edge) state_d = ST_RIGHT;
                ST_RIGHT: if (frame_edge) state_d = ST_LEFT;
                default:                  state_d = ST_IDLE;
            endcase

            // Next-state words are used so a left-justified MSB can go out in slot 0 of the loading edge.
            sel_word = (state_d == ST_RIGHT) ? shift_r_d : shift_l_d;
`ifdef I2S_LEFT_JUSTIFIED_EN
            if (slot_d < 6'd24) begin
                bit_on  = 1'b1;
                bit_idx = 5'(6'd23 - slot_d);
            end
`else
            if (slot_d != 6'd0 && slot_d <= 6'd24) begin
                bit_on  = 1'b1;
                bit_idx = 5'(6'd24 - slot_d);
            end
`endif
            sdata_d = (state_d != ST_IDLE) && bit_on && sel_word[bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mclk_q      <= 1'b0;
            sclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            shift_l_q   <= '0;
            shift_r_q   <= '0;
            state_q     <= ST_IDLE;
            slot_q      <= '0;
        end else begin
            mclk_q      <= mclk_d;
            sclk_q      <= sclk_d;
            lrck_q      <= lrck_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            state_q     <= state_d;
            slot_q      <= slot_d;
        end
    end

    assign sample_ready = ~hold_full_q;
    assign sclk         = sclk_q;
    assign lrck_out     = lrck_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame-level reference model compared every clk, plus a serial collector pinned to literal frames.
// Honours I2S_LEFT_JUSTIFIED_EN the same way the design does.
`timescale 1ns/1ps

module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        mclk_in;
    logic        lrck_in;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        sclk;
    logic        lrck_out;
    logic        sdata;
    logic        underrun;

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic [23:0] L_PAT = 24'h800001;
`else
    localparam logic [23:0] L_PAT = 24'hA5F00F;
`endif
    localparam logic [23:0] R_PAT = 24'h123456;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    i2s_tx dut (
        .clk          (clk),
        .rst          (rst),
        .mclk_in      (mclk_in),
        .lrck_in      (lrck_in),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sclk         (sclk),
        .lrck_out     (lrck_out),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Bit position carried by a given slot, or -1 when that slot must be 0.
    function automatic int bit_pos(input int s);
`ifdef I2S_LEFT_JUSTIFIED_EN
        return (s <= 23) ? 23 - s : -1;
`else
        return (s >= 1 && s <= 24) ? 24 - s : -1;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [23:0] l, input logic [23:0] r);
        sample_valid = v;
        sample_l     = l;
        sample_r     = r;
    endtask

    // Divider emulation: mclk and lrck as free-running square waves in clk cycles.
    int mclk_half = 3;
    int lrck_half = 1537;
    int mcnt = 0;
    int lcnt = 0;
    bit gen_stall = 1'b0;

    initial begin
        mclk_in = 1'b0;
        lrck_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!gen_stall) begin
                mcnt++;
                if (mcnt >= mclk_half) begin
                    mcnt    = 0;
                    mclk_in = ~mclk_in;
                end
            end
            lcnt++;
            if (lcnt >= lrck_half) begin
                lcnt    = 0;
                lrck_in = ~lrck_in;
            end
        end
    end

    // Reference model: counts mclk rises, sclk falls and slots; a queue stands in for the holding register.
    bit          m_mclk_prev, m_sclk, m_lrck, m_sdata, m_underrun, m_running;
    bit          m_rise, m_fall, m_accept;
    int          m_slot, m_pos;
    logic [23:0] m_frame_l, m_frame_r, m_word;
    logic [47:0] m_pending[$];
    logic [47:0] m_pair;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_mclk_prev = 0; m_sclk = 0; m_lrck = 0; m_sdata = 0;
            m_underrun = 0; m_running = 0; m_slot = 0;
            m_frame_l = '0; m_frame_r = '0;
            m_pending.delete();
        end else begin
            m_rise      = mclk_in && !m_mclk_prev;
            m_mclk_prev = mclk_in;
            m_accept    = sample_valid && (m_pending.size() == 0);
            m_fall      = m_rise && m_sclk;
            if (m_rise) m_sclk = !m_sclk;
            m_underrun  = 0;
            if (m_fall) begin
                if (lrck_in != m_lrck) begin
                    if (m_lrck && !lrck_in) begin
                        m_running = 1;
                        if (m_pending.size() > 0) begin
                            m_pair    = m_pending.pop_front();
                            m_frame_l = m_pair[47:24];
                            m_frame_r = m_pair[23:0];
                        end else begin
                            m_underrun = 1;
                        end
                    end
                    m_slot = 0;
                end else if (m_slot < 63) begin
                    m_slot++;
                end
                m_lrck = lrck_in;
                if (!m_running) begin
                    m_sdata = 0;
                end else begin
                    m_word  = m_lrck ? m_frame_r : m_frame_l;
                    m_pos   = bit_pos(m_slot);
                    m_sdata = (m_pos < 0) ? 1'b0 : m_word[m_pos];
                end
            end
            if (m_accept) m_pending.push_back({sample_l, sample_r});
        end
    end

    logic cmp_prev_lrck, cmp_prev_sclk;

    always @(negedge clk) begin
        checkOutput("sclk/lrck/sdata/underrun/ready",
                    {27'd0, sclk, lrck_out, sdata, underrun, sample_ready},
                    {27'd0, m_sclk, m_lrck, m_sdata, m_underrun, m_pending.size() == 0});
        if (!rst && lrck_out !== cmp_prev_lrck)
            checkOutput("lrck_edge_on_sclk_fall", {30'd0, cmp_prev_sclk, sclk}, 32'd2);
        cmp_prev_lrck = lrck_out;
        cmp_prev_sclk = sclk;
    end

    // Serial collector: rebuilds each frame the way a DAC would, sampling sdata on sclk rises.
    typedef struct {
        bit          ch;
        bit          extra;
        logic [23:0] word;
    } frame_t;

    frame_t      c_q[$];
    bit          c_on, c_extra;
    int          c_slot, c_pos, c_underruns, c_last_rise, c_period;
    logic [23:0] c_word;
    logic        c_prev_sclk, c_prev_lrck;

    always @(negedge clk) begin
        if (rst) begin
            c_q.delete();
            c_on = 0; c_slot = 0; c_word = '0; c_extra = 0; c_underruns = 0;
        end else begin
            if (underrun === 1'b1) c_underruns++;
            if (lrck_out !== c_prev_lrck) begin
                if (c_on) c_q.push_back('{ch: c_prev_lrck, extra: c_extra, word: c_word});
                if (lrck_out === 1'b0) c_on = 1;
                c_slot = 0; c_word = '0; c_extra = 0;
            end else if (sclk === 1'b1 && c_prev_sclk === 1'b0) begin
                c_period    = cyc - c_last_rise;
                c_last_rise = cyc;
                c_pos = bit_pos(c_slot);
                if (c_pos >= 0) c_word[c_pos] = sdata;
                else            c_extra = c_extra | sdata;
                c_slot++;
            end
        end
        c_prev_sclk = sclk;
        c_prev_lrck = lrck_out;
    end

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (c_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (c_q.size() < n) checkOutput("frame_wait_timeout", c_q.size(), n);
    endtask

    task automatic wait_lrck_fall(input int budget, output int ones);
        logic prev;
        int   k = 0;
        bit   seen = 0;
        ones = 0;
        prev = lrck_out;
        while (!seen && k < budget) begin
            @(negedge clk);
            k++;
            if (sdata === 1'b1) ones++;
            if (prev === 1'b1 && lrck_out === 1'b0) seen = 1;
            prev = lrck_out;
        end
        if (!seen) checkOutput("lrck_fall_timeout", 0, 1);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int ready_run, ready_max, ones;

    initial begin
        rst = 1'b1;
        applyStimulus(0, '0, '0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", sample_ready, 1);
        checkOutput("reset_sclk_lrck_sdata_underrun", {sclk, lrck_out, sdata, underrun}, 0);

        // Directed: one pair before the first frame, then starve the second frame.
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1, L_PAT, R_PAT);
        @(posedge clk);
        @(negedge clk);
        checkOutput("ready_after_load", sample_ready, 0);
        applyStimulus(0, '0, '0);

        wait_frames(3, 10000);
        checkOutput("left_frame1",  {6'd0, c_q[0].ch, c_q[0].extra, c_q[0].word}, {8'd0, L_PAT});
        checkOutput("right_frame1", {6'd0, c_q[1].ch, c_q[1].extra, c_q[1].word}, {8'h2, R_PAT});
        checkOutput("left_frame2_repeat", {6'd0, c_q[2].ch, c_q[2].extra, c_q[2].word}, {8'd0, L_PAT});
        checkOutput("underrun_cycles_after_frame2", c_underruns, 1);
        wait_frames(4, 4000);
        checkOutput("right_frame2_repeat", {6'd0, c_q[3].ch, c_q[3].extra, c_q[3].word}, {8'h2, R_PAT});
        checkOutput("underrun_cycles_after_frame3", c_underruns, 2);
        checkOutput("sclk_period", c_period, 12);

        // valid held high: ready may only open for a single clk after each left edge.
        lrck_half = 400;
        ready_run = 0;
        ready_max = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            applyStimulus(1, 24'($urandom), 24'($urandom));
            @(negedge clk);
            if (sample_ready === 1'b1) ready_run++;
            else                       ready_run = 0;
            if (ready_run > ready_max) ready_max = ready_run;
        end
        checkOutput("ready_pulse_width", ready_max, 1);
        applyStimulus(0, '0, '0);

        // Reset pulse in the middle of a left frame.
        wait_lrck_fall(2000, ones);
        repeat (100) @(negedge clk);
        checkOutput("in_left_before_reset", lrck_out, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_mid_frame", {sclk, lrck_out, sdata, underrun, sample_ready}, 5'b00001);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_lrck_fall(3000, ones);
        checkOutput("sdata_zero_until_first_left", ones, 0);

        // Randomised traffic: varied frame lengths (some shorter than 25 slots), mclk stalls, sparse resets.
        for (int seg = 0; seg < 25; seg++) begin
            @(posedge clk); #1;
            lrck_half = $urandom_range(40, 700);
            mclk_half = $urandom_range(1, 4);
            gen_stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                @(posedge clk); #1;
                rst = 1'b0;
            end
            for (int n = $urandom_range(200, 1500); n > 0; n--) begin
                @(posedge clk); #1;
                applyStimulus($urandom_range(0, 3) == 0, 24'($urandom), 24'($urandom));
            end
        end
        gen_stall = 1'b0;
        applyStimulus(0, '0, '0);
        repeat (20) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
